// File: rtl/chan_ctrl_pkg.sv
// chan_ctrl_pkg: shared definitions for the channel controller.
//   - 2-bit encoding of the key auto-repeat FSM states
//   - clog2w(): ceil(log2(n)) clamped to a minimum width of 1
package chan_ctrl_pkg;

    typedef logic [1:0] rpt_state_t;

    localparam rpt_state_t IDLE   = 2'd0;
    localparam rpt_state_t DELAY  = 2'd1;
    localparam rpt_state_t REPEAT = 2'd2;

    function automatic int unsigned clog2w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_repeat.sv
// key_repeat: auto-repeat engine for the up/down keys.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   tick_i                 timebase strobe, one clk wide
//   up_i, down_i           raw key levels
//   up_rise_i, down_rise_i rising edges of the keys (already qualified)
//   step_up_o, step_down_o one-clk step pulses (press step and repeat steps)
module key_repeat
    import chan_ctrl_pkg::*;
#(
    parameter int unsigned REPEAT_DLY  = 50,
    parameter int unsigned REPEAT_RATE = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic up_i,
    input  logic down_i,
    input  logic up_rise_i,
    input  logic down_rise_i,
    output logic step_up_o,
    output logic step_down_o
);

    localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned CNT_W   = clog2w(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

    rpt_state_t       state_q, state_d;
    logic             dir_up_q, dir_up_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic held_up, held_down, held_dir;
    logic press_up, press_down;
    logic fire;

    // "Held" means exactly one key down; both pressed counts as released.
    assign held_up    = up_i & ~down_i;
    assign held_down  = down_i & ~up_i;
    // Held in the latched direction; a direction swap drops this and returns to IDLE.
    assign held_dir   = dir_up_q ? held_up : held_down;
    assign press_up   = up_rise_i & held_up;
    assign press_down = down_rise_i & held_down;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            dir_up_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dir_up_q <= dir_up_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (press_up || press_down) begin
                    state_d  = DELAY;
                    dir_up_d = press_up;
                    cnt_d    = '0;
                end
            end
            DELAY: begin
                if (!held_dir) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (cnt_q == DLY_LAST) begin
                        state_d = REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            REPEAT: begin
                if (!held_dir) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (cnt_q == RATE_LAST) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        fire = 1'b0;
        if (held_dir && tick_i) begin
            if (state_q == DELAY && cnt_q == DLY_LAST) begin
                fire = 1'b1;
            end else if (state_q == REPEAT && cnt_q == RATE_LAST) begin
                fire = 1'b1;
            end
        end
        step_up_o   = ((state_q == IDLE) && press_up) || (fire && dir_up_q);
        step_down_o = ((state_q == IDLE) && press_down) || (fire && !dir_up_q);
    end

endmodule

// File: rtl/chan_ctrl.sv
// chan_ctrl: channel selector with up/down keys (auto-repeat), last-channel
// recall and direct select.
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   tick_i            timebase strobe for auto-repeat
//   up_i, down_i      step keys (level)
//   recall_i          last-channel key (level)
//   sel_valid_i       direct-select strobe; sel_ch_i is the requested channel
//   ch_idx_o          current channel, binary
//   ch_onehot_o       current channel, one-hot
//   ch_changed_o      one-clk pulse when ch_idx_o takes a new value
module chan_ctrl
    import chan_ctrl_pkg::*;
#(
    parameter int unsigned NCH         = 8,
    parameter int unsigned WRAP        = 1,
    parameter int unsigned REPEAT_DLY  = 50,
    parameter int unsigned REPEAT_RATE = 10,
    localparam int unsigned CW         = clog2w(NCH)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           tick_i,
    input  logic           up_i,
    input  logic           down_i,
    input  logic           recall_i,
    input  logic           sel_valid_i,
    input  logic [CW-1:0]  sel_ch_i,
    output logic [CW-1:0]  ch_idx_o,
    output logic [NCH-1:0] ch_onehot_o,
    output logic           ch_changed_o
);

    localparam logic [CW:0]   NCH_W = (CW + 1)'(NCH);
    localparam logic [CW-1:0] LAST  = CW'(NCH - 1);

    logic          up_q, down_q, recall_q;
    logic          armed_q;
    logic [CW-1:0] ch_q, ch_d;
    logic [CW-1:0] prev_q, prev_d;
    logic          changed_q, changed_d;

    logic up_rise, down_rise, recall_rise;
    logic step_up, step_down;
    logic sel_in_range;

    // armed_q masks rises on the first clk after reset so a key held through
    // reset release only loads its delay register and does not step.
    assign up_rise      = up_i & ~up_q & armed_q;
    assign down_rise    = down_i & ~down_q & armed_q;
    assign recall_rise  = recall_i & ~recall_q & armed_q;
    assign sel_in_range = ({1'b0, sel_ch_i} < NCH_W);

    key_repeat #(
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_key_repeat (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .tick_i      (tick_i),
        .up_i        (up_i),
        .down_i      (down_i),
        .up_rise_i   (up_rise),
        .down_rise_i (down_rise),
        .step_up_o   (step_up),
        .step_down_o (step_down)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            recall_q  <= 1'b0;
            armed_q   <= 1'b0;
            ch_q      <= '0;
            prev_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            up_q      <= up_i;
            down_q    <= down_i;
            recall_q  <= recall_i;
            armed_q   <= 1'b1;
            ch_q      <= ch_d;
            prev_q    <= prev_d;
            changed_q <= changed_d;
        end
    end

    // One action per clk: select > recall > step. An out-of-range select
    // still claims the cycle, and steps lose to either higher action.
    always_comb begin
        ch_d   = ch_q;
        prev_d = prev_q;
        if (sel_valid_i) begin
            if (sel_in_range && (sel_ch_i != ch_q)) begin
                ch_d   = sel_ch_i;
                prev_d = ch_q;
            end
        end else if (recall_rise) begin
            ch_d   = prev_q;
            prev_d = ch_q;
        end else if (step_up) begin
            if (ch_q == LAST) begin
                if (WRAP != 0) begin
                    ch_d = '0;
                end
            end else begin
                ch_d = ch_q + CW'(1);
            end
            if (ch_d != ch_q) begin
                prev_d = ch_q;
            end
        end else if (step_down) begin
            if (ch_q == '0) begin
                if (WRAP != 0) begin
                    ch_d = LAST;
                end
            end else begin
                ch_d = ch_q - CW'(1);
            end
            if (ch_d != ch_q) begin
                prev_d = ch_q;
            end
        end
        changed_d = (ch_d != ch_q);
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_onehot_o[i] = (ch_q == CW'(i));
        end
    end

    assign ch_idx_o     = ch_q;
    assign ch_changed_o = changed_q;

endmodule
